regfile_seq_ctrl: RTL and testbench

- Command sequencer for the 32x16 register file: accepts one register-transfer/ALU command per valid/ready handshake.
- Drives the register file's two combinational read ports and its single write port through a fixed 4-state FSM, one command in flight at a time.
- Sits between a test/command source (switches, UART decoder or bench) and the register file instance; it owns every regfile port.

---
 rtl/regfile_seq_pkg.sv | 14 +
 rtl/regfile_seq_ctrl_if.sv | 12 +
 rtl/regfile_seq_alu.sv | 22 ++
 rtl/regfile_seq_ctrl.sv | 89 ++++++++
 tb/tb_regfile_seq_ctrl.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/regfile_seq_pkg.sv
// regfile_seq_pkg: shared opcodes, FSM state encoding and default widths for the regfile sequencer.
package regfile_seq_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_LDI  = 3'd4;
    localparam logic [2:0] OP_ADDI = 3'd5;
    localparam logic [2:0] OP_MOV  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_EXEC, ST_WRITE} stateT;
endpackage

// File: rtl/regfile_seq_ctrl_if.sv
// regfile_seq_ctrl_if: valid/ready command channel into the sequencer.
interface regfile_seq_ctrl_if #(parameter int DATA_W = 16, parameter int ADDR_W = 5);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_rd;
    logic [ADDR_W-1:0] cmd_rs;
    logic [ADDR_W-1:0] cmd_rt;
    logic [DATA_W-1:0] cmd_imm;
    modport master (output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm, output cmd_ready);
endinterface

// File: rtl/regfile_seq_alu.sv
// regfile_seq_alu: combinational datapath for one sequencer command, arithmetic wraps modulo 2^DATA_W.
module regfile_seq_alu
    import regfile_seq_pkg::*;
#(
    parameter int DATA_W = regfile_seq_pkg::DATA_W
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result
);
    always_comb begin
        result = op == OP_ADD  ? a + b :
                 op == OP_SUB  ? a - b :
                 op == OP_AND  ? a & b :
                 op == OP_OR   ? a | b :
                 op == OP_LDI  ? imm :
                 op == OP_ADDI ? a + imm :
                 op == OP_MOV  ? a : '0;
    end
endmodule

// File: rtl/regfile_seq_ctrl.sv
// regfile_seq_ctrl: 4-state IDLE/READ/EXEC/WRITE command sequencer owning all register-file ports.
// Optional REGFILE_SEQ_ZERO_REG_EN makes r0 a hardwired zero (reads forced to 0, writes dropped).
module regfile_seq_ctrl
    import regfile_seq_pkg::*;
#(
    parameter int DATA_W = regfile_seq_pkg::DATA_W,
    parameter int ADDR_W = regfile_seq_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_seq_ctrl_if.slave cmd,
    output logic [ADDR_W-1:0] rf_raddr_a,
    output logic [ADDR_W-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result,
    output logic              zero
);
    stateT             state, nextState;
    logic [2:0]        opReg;
    logic [ADDR_W-1:0] rdReg;
    logic [DATA_W-1:0] immReg, opA, opB, aluReg, aluOut;
    logic              rsvd;
    regfile_seq_alu #(.DATA_W(DATA_W)) alu (.op(opReg), .a(opA), .b(opB), .imm(immReg), .result(aluOut));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= nextState;
    end
    always_comb begin
        nextState = state == ST_IDLE ? (cmd.cmd_valid ? ST_READ : ST_IDLE) :
                    state == ST_READ ? ST_EXEC :
                    state == ST_EXEC ? ST_WRITE : ST_IDLE;
    end
    always_comb begin
        rsvd          = opReg == OP_RSVD;
        cmd.cmd_ready = state == ST_IDLE;
        done          = state == ST_WRITE;
        err           = done && rsvd;
`ifdef REGFILE_SEQ_ZERO_REG_EN
        rf_we         = done && !rsvd && rdReg != '0;
`else
        rf_we         = done && !rsvd;
`endif
        rf_waddr      = rdReg;
        rf_wdata      = aluReg;
    end
    // Published result/zero only move when a non-reserved command retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opReg      <= '0;
            rdReg      <= '0;
            rf_raddr_a <= '0;
            rf_raddr_b <= '0;
            immReg     <= '0;
            opA        <= '0;
            opB        <= '0;
            aluReg     <= '0;
            result     <= '0;
            zero       <= 1'b0;
        end else begin
            if (state == ST_IDLE && cmd.cmd_valid) begin
                opReg      <= cmd.cmd_op;
                rdReg      <= cmd.cmd_rd;
                rf_raddr_a <= cmd.cmd_rs;
                rf_raddr_b <= cmd.cmd_rt;
                immReg     <= cmd.cmd_imm;
            end
            if (state == ST_READ) begin
`ifdef REGFILE_SEQ_ZERO_REG_EN
                opA <= rf_raddr_a == '0 ? '0 : rf_rdata_a;
                opB <= rf_raddr_b == '0 ? '0 : rf_rdata_b;
`else
                opA <= rf_rdata_a;
                opB <= rf_rdata_b;
`endif
            end
            if (state == ST_EXEC) aluReg <= aluOut;
            if (state == ST_WRITE && !rsvd) begin
                result <= aluReg;
                zero   <= aluReg == '0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// tb_regfile_seq_ctrl: directed vector table plus reset/abort sequences against a behavioural 32x16 register file.
module tb_regfile_seq_ctrl;
    import regfile_seq_pkg::*;
    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd, rs, rt;
        logic [15:0] imm;
        logic        we, er;
        logic [15:0] res;
        logic        z;
    } vecT;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata, result;
    logic        rf_we, done, err, zero;
    logic [15:0] regs [32] = '{0: 16'h00AA, 8: 16'hBEEF, default: 16'h0000};
    int          total = 0;
    int          bad = 0;
    vecT         vecs [14];
    regfile_seq_ctrl_if #(.DATA_W(16), .ADDR_W(5)) cmd ();
    regfile_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .done(done), .err(err), .result(result), .zero(zero)
    );
    always #5 clk = ~clk;
    assign rf_rdata_a = regs[rf_raddr_a];
    assign rf_rdata_b = regs[rf_raddr_b];
    always @(posedge clk) if (rf_we) regs[rf_waddr] <= rf_wdata;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask
    function automatic vecT mk(input logic [2:0] op, input logic [4:0] rd, rs, rt, input logic [15:0] imm,
                               input logic we, er, input logic [15:0] res, input logic z);
        vecT v;
        v.op = op; v.rd = rd; v.rs = rs; v.rt = rt; v.imm = imm;
        v.we = we; v.er = er; v.res = res; v.z = z;
        return v;
    endfunction
    task automatic runCmd(input vecT v);
        int doneAt, weCnt, lowCnt;
        logic [4:0]  wa;
        logic [15:0] wd;
        logic        er;
        @(negedge clk);
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op = v.op; cmd.cmd_rd = v.rd; cmd.cmd_rs = v.rs; cmd.cmd_rt = v.rt; cmd.cmd_imm = v.imm;
        chk("ready_idle", {31'd0, cmd.cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op = ~v.op; cmd.cmd_rd = ~v.rd; cmd.cmd_rs = ~v.rs; cmd.cmd_rt = ~v.rt; cmd.cmd_imm = ~v.imm;
        doneAt = 0; weCnt = 0; lowCnt = 0; wa = '0; wd = '0; er = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (rf_we) begin weCnt++; wa = rf_waddr; wd = rf_wdata; end
            if (done) begin doneAt = doneAt == 0 ? n : 99; er = err; end
            if (!cmd.cmd_ready) lowCnt++;
        end
        chk("done_latency", doneAt, 3);
        chk("ready_low_cycles", lowCnt, 3);
        chk("we_count", weCnt, {31'd0, v.we});
        if (v.we) begin
            chk("waddr", {27'd0, wa}, {27'd0, v.rd});
            chk("wdata", {16'd0, wd}, {16'd0, v.res});
        end
        chk("err", {31'd0, er}, {31'd0, v.er});
        chk("result", {16'd0, result}, {16'd0, v.res});
        chk("zero", {31'd0, zero}, {31'd0, v.z});
    endtask
    initial begin
        cmd.cmd_valid = 1'b0; cmd.cmd_op = '0; cmd.cmd_rd = '0; cmd.cmd_rs = '0; cmd.cmd_rt = '0; cmd.cmd_imm = '0;
        vecs[0]  = mk(OP_LDI,  5'd3,  5'd0, 5'd0, 16'h1234, 1'b1, 1'b0, 16'h1234, 1'b0);
        vecs[1]  = mk(OP_LDI,  5'd1,  5'd0, 5'd0, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b0);
        vecs[2]  = mk(OP_LDI,  5'd2,  5'd0, 5'd0, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b0);
        vecs[3]  = mk(OP_ADD,  5'd4,  5'd1, 5'd2, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
        vecs[4]  = mk(OP_SUB,  5'd5,  5'd3, 5'd3, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
        vecs[5]  = mk(OP_ADDI, 5'd6,  5'd5, 5'd0, 16'h0007, 1'b1, 1'b0, 16'h0007, 1'b0);
        vecs[6]  = mk(OP_AND,  5'd9,  5'd3, 5'd1, 16'h0000, 1'b1, 1'b0, 16'h1234, 1'b0);
        vecs[7]  = mk(OP_OR,   5'd10, 5'd3, 5'd2, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0);
        vecs[8]  = mk(OP_SUB,  5'd11, 5'd2, 5'd1, 16'h0000, 1'b1, 1'b0, 16'h0002, 1'b0);
        vecs[9]  = mk(OP_MOV,  5'd12, 5'd3, 5'd0, 16'h0000, 1'b1, 1'b0, 16'h1234, 1'b0);
        vecs[10] = mk(OP_RSVD, 5'd13, 5'd1, 5'd2, 16'h00FF, 1'b0, 1'b1, 16'h1234, 1'b0);
`ifdef REGFILE_SEQ_ZERO_REG_EN
        vecs[11] = mk(OP_LDI,  5'd0,  5'd0, 5'd0, 16'h0055, 1'b0, 1'b0, 16'h0055, 1'b0);
        vecs[12] = mk(OP_MOV,  5'd7,  5'd0, 5'd0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
`else
        vecs[11] = mk(OP_LDI,  5'd0,  5'd0, 5'd0, 16'h0055, 1'b1, 1'b0, 16'h0055, 1'b0);
        vecs[12] = mk(OP_MOV,  5'd7,  5'd0, 5'd0, 16'h0000, 1'b1, 1'b0, 16'h0055, 1'b0);
`endif
        vecs[13] = mk(OP_ADD,  5'd3,  5'd3, 5'd2, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, cmd.cmd_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_raddr", {22'd0, rf_raddr_a, rf_raddr_b}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) runCmd(vecs[i]);
        chk("r4_wrap", {16'd0, regs[4]}, 32'h0000);
        chk("r6_dep", {16'd0, regs[6]}, 32'h0007);
        chk("r3_rd_eq_rs", {16'd0, regs[3]}, 32'h1235);
`ifdef REGFILE_SEQ_ZERO_REG_EN
        chk("r7_from_r0", {16'd0, regs[7]}, 32'h0000);
`else
        chk("r7_from_r0", {16'd0, regs[7]}, 32'h0055);
`endif
        @(negedge clk);
        cmd.cmd_valid = 1'b1; cmd.cmd_op = OP_ADD; cmd.cmd_rd = 5'd8; cmd.cmd_rs = 5'd1; cmd.cmd_rt = 5'd2;
        @(posedge clk);
        #1 cmd.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, cmd.cmd_ready}, 32'd1);
        chk("abort_we", {31'd0, rf_we}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", {16'd0, result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("abort_no_we", {31'd0, rf_we}, 32'd0);
        end
        chk("r8_kept", {16'd0, regs[8]}, 32'hBEEF);
        runCmd(mk(OP_ADD, 5'd8, 5'd1, 5'd6, 16'h0000, 1'b1, 1'b0, 16'h0006, 1'b0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
